fifo_wr_arbiter: RTL and testbench

- Round-robin write-side arbiter that shares one FIFO write port (wr_data / wr_en / full / almost_full, write clock domain) among NUM_REQ valid/ready requesters.
- Grants the port for bursts of up to MAX_BURST words, so words from a given requester stay contiguous in the FIFO.
- Never asserts the FIFO write enable while the FIFO reports full.
- Sits in the FIFO write clock domain, directly in front of the FIFO.

---
 rtl/fifo_wr_arbiter.sv | 106 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters
// Define FIFO_WR_ARB_AF_THROTTLE_EN to suppress new grants while fifo_almost_full is high.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [DATA_WIDTH-1:0]          fifo_wr_data,
    output logic                           fifo_wr_en,
    input  logic                           fifo_full,
    input  logic                           fifo_almost_full,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state;
    logic [IDW-1:0] rr_last;
    logic [BCW-1:0] burst_cnt;

    logic [IDW-1:0] arb_winner;
    logic           arb_found;
    logic           throttle;
    logic           ready_any;
    logic           last_beat;
    logic           release_grant;
    logic           new_grant_ok;

`ifdef FIFO_WR_ARB_AF_THROTTLE_EN
    assign throttle = fifo_almost_full;
`else
    logic unused_af;
    assign unused_af = fifo_almost_full;
    assign throttle  = 1'b0;
`endif

    // Scan starts just after the last winner, so the current grantee is checked last.
    always_comb begin : arb
        int idx;
        idx        = 0;
        arb_winner = '0;
        arb_found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_last) + k) % NUM_REQ;
            if (!arb_found && req_valid[idx]) begin
                arb_found  = 1'b1;
                arb_winner = IDW'(idx);
            end
        end
    end

    assign ready_any     = !rst && (state == GRANT) && !fifo_full;
    assign req_ready     = ready_any ? (NUM_REQ'(1) << grant_id) : '0;
    assign fifo_wr_en    = ready_any && req_valid[grant_id];
    assign fifo_wr_data  = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign busy          = (state == GRANT);

    assign last_beat     = fifo_wr_en && (burst_cnt == BCW'(MAX_BURST - 1));
    assign release_grant = last_beat || !req_valid[grant_id];
    assign new_grant_ok  = arb_found && !throttle;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_id  <= '0;
            rr_last   <= IDW'(NUM_REQ - 1);
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (new_grant_ok) begin
                        state     <= GRANT;
                        grant_id  <= arb_winner;
                        rr_last   <= arb_winner;
                        burst_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        // Re-arbitrate in the releasing cycle for a bubble-free hand-off.
                        if (new_grant_ok) begin
                            grant_id  <= arb_winner;
                            rr_last   <= arb_winner;
                            burst_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (fifo_wr_en) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [DW-1:0]     fifo_wr_data;
    logic              fifo_wr_en;
    logic              fifo_full;
    logic              fifo_almost_full;
    logic [1:0]        grant_id;
    logic              busy;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .fifo_wr_data     (fifo_wr_data),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .grant_id         (grant_id),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [17:0] exp_q[$];
    logic [17:0] mon_e;
    int          cnt[NR];
    int          nxt[NR];
    logic [NR-1:0] acc_q = '0;

    function automatic logic [15:0] word(input int i, input int n);
        return 16'((i << 12) | (n & 'hfff));
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic push(input int i, input int n);
        exp_q.push_back({2'(i), word(i, n)});
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = (cnt[i] != 0);
            req_data[i*DW +: DW]  = word(i, nxt[i]);
        end
    endtask

    task automatic load(input int i, input int c, input int b);
        cnt[i] = c;
        nxt[i] = b;
        drive();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc_q[i]) begin
                cnt[i]--;
                nxt[i]++;
            end
        end
        drive();
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NR; i++) if (cnt[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name, input int max);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max && !done; k++) begin
            step();
            smp();
            if (!busy && all_empty()) done = 1'b1;
        end
        check(name, 32'(done), 1);
    endtask

    task automatic wait_wr(input string name, input int n);
        int seen;
        seen = 0;
        for (int k = 0; k < 50 && seen < n; k++) begin
            step();
            smp();
            if (fifo_wr_en) seen++;
        end
        check(name, seen, n);
    endtask

    // Monitor: every FIFO write must match the head of the expected queue.
    always @(negedge clk) begin
        acc_q = req_valid & req_ready;
        if (fifo_wr_en === 1'b1) begin
            check("no_wr_while_full", 32'(fifo_full), 0);
            check("ready_onehot", 32'(req_ready), 32'(NR'(1) << grant_id));
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got %0h, expected no write", {grant_id, fifo_wr_data});
            end else begin
                mon_e = exp_q.pop_front();
                check("write_word", 32'({grant_id, fifo_wr_data}), 32'(mon_e));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst              = 1'b1;
        fifo_full        = 1'b0;
        fifo_almost_full = 1'b0;
        req_valid        = '0;
        req_data         = '0;
        for (int i = 0; i < NR; i++) load(i, 8, 0);
        for (int r = 0; r < 2; r++)
            for (int q = 0; q < NR; q++)
                for (int k = 0; k < MB; k++) push(q, r*MB + k);

        // Reset with every requester valid
        for (int c = 0; c < 2; c++) begin
            smp();
            check("rst_wr_en", 32'(fifo_wr_en), 0);
            check("rst_ready", 32'(req_ready), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_gid", 32'(grant_id), 0);
        end
        step();
        rst = 1'b0;
        smp();
        check("first_cycle_no_wr", 32'(fifo_wr_en), 0);
        check("first_cycle_idle", 32'(busy), 0);
        step();
        smp();
        check("first_grant_busy", 32'(busy), 1);
        check("first_grant_gid", 32'(grant_id), 0);
        check("first_write", 32'(fifo_wr_en), 1);
        n = fifo_wr_en ? 1 : 0;
        for (int c = 0; c < 15; c++) begin
            step();
            smp();
            if (fifo_wr_en) n++;
        end
        check("rr_16_in_16", n, 16);
        wait_idle("rr_drain", 40);

        // Short burst from req 2, then a later single word
        step();
        load(2, 2, 'h100);
        push(2, 'h100);
        push(2, 'h101);
        smp();
        wait_idle("short_idle", 10);
        check("short_hold_gid", 32'(grant_id), 2);
        check("short_busy", 32'(busy), 0);
        step();
        load(2, 1, 'h200);
        push(2, 'h200);
        smp();
        wait_idle("short_again", 10);
        check("short_again_gid", 32'(grant_id), 2);

        // Full stall after word 2 of req 0's burst
        step();
        load(0, 4, 'h300);
        load(1, 4, 'h300);
        for (int k = 0; k < 4; k++) push(0, 'h300 + k);
        for (int k = 0; k < 4; k++) push(1, 'h300 + k);
        smp();
        wait_wr("stall_w2", 2);
        step();
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) step();
            smp();
            check("stall_wr_en", 32'(fifo_wr_en), 0);
            check("stall_ready", 32'(req_ready), 0);
            check("stall_gid", 32'(grant_id), 0);
            check("stall_busy", 32'(busy), 1);
        end
        step();
        fifo_full = 1'b0;
        smp();
        check("stall_resume", 32'(fifo_wr_en), 1);
        check("stall_resume_gid", 32'(grant_id), 0);
        wait_idle("stall_drain", 30);

        // Reset on the cycle req 1 would write its third word
        step();
        load(1, 4, 'h400);
        push(1, 'h400);
        push(1, 'h401);
        push(0, 'h500);
        push(0, 'h501);
        push(1, 'h402);
        push(1, 'h403);
        smp();
        wait_wr("rst_w2", 2);
        step();
        rst = 1'b1;
        load(0, 2, 'h500);
        smp();
        check("midrst_wr_en", 32'(fifo_wr_en), 0);
        check("midrst_ready", 32'(req_ready), 0);
        step();
        rst = 1'b0;
        smp();
        check("postrst_busy", 32'(busy), 0);
        check("postrst_gid", 32'(grant_id), 0);
        wait_wr("postrst_w1", 1);
        check("postrst_grant0", 32'(grant_id), 0);
        wait_idle("rst_drain", 30);

        // almost_full raised during req 0's burst
        step();
        load(0, 4, 'h600);
        load(1, 4, 'h600);
        for (int k = 0; k < 4; k++) push(0, 'h600 + k);
        for (int k = 0; k < 4; k++) push(1, 'h600 + k);
        smp();
        wait_wr("af_w1", 1);
        step();
        fifo_almost_full = 1'b1;
        smp();
        check("af_burst_continues", 32'(fifo_wr_en), 1);
        wait_wr("af_w34", 2);
        step();
        smp();
`ifdef FIFO_WR_ARB_AF_THROTTLE_EN
        check("af_no_grant_wr", 32'(fifo_wr_en), 0);
        check("af_no_grant_busy", 32'(busy), 0);
        for (int c = 0; c < 2; c++) begin
            step();
            smp();
            check("af_hold_idle", 32'(busy), 0);
        end
        step();
        fifo_almost_full = 1'b0;
        smp();
        wait_wr("af_resume", 1);
        check("af_resume_gid", 32'(grant_id), 1);
`else
        check("af_ignored_wr", 32'(fifo_wr_en), 1);
        check("af_ignored_gid", 32'(grant_id), 1);
        step();
        fifo_almost_full = 1'b0;
        smp();
`endif
        wait_idle("af_drain", 30);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
